// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro EX_MULDIV_FAST_MUL_EN: ops 0-3 use a single-cycle (XLEN+1)x(XLEN+1) signed multiplier.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      gprs_waddr_i,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [4:0]      gprs_waddr_o,
  output logic [XLEN-1:0] gprs_wdata_o
);

  // state | meaning
  // IDLE  | waiting for an op from ID
  // BUSY  | iterating, one multiply step or quotient bit per cycle
  // DONE  | result presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [4:0]       REG_X0   = 5'd0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_state_nx;

  logic [2:0]       r_op;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_hi, r_lo, r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r, r_div;
  logic             r_busy, r_done;
  logic [4:0]       r_waddr;
  logic [XLEN-1:0]  r_wdata;

  logic            w_accept;
  logic            w_s1_signed, w_s2_signed, w_neg1, w_neg2;
  logic [XLEN-1:0] w_abs1, w_abs2;
  logic            w_div0, w_ovf, w_direct;
  logic [XLEN-1:0] w_direct_res;

  // Operand decode for the op being issued this cycle
  always_comb begin
    w_s1_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    w_s2_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    w_neg1      = w_s1_signed & src1[XLEN-1];
    w_neg2      = w_s2_signed & src2[XLEN-1];
    w_abs1      = w_neg1 ? (~src1 + 1'b1) : src1;
    w_abs2      = w_neg2 ? (~src2 + 1'b1) : src2;
    w_div0      = op[2] & (src2 == '0);
    w_ovf       = ((op == 3'd4) || (op == 3'd6)) & (src1 == MIN_NEG) & (src2 == '1);
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic        [2*XLEN-1:0] w_fprod;

  always_comb begin
    w_fa    = {w_s1_signed & src1[XLEN-1], src1};
    w_fb    = {w_s2_signed & src2[XLEN-1], src2};
    w_fprod = w_fa * w_fb;
  end

  always_comb begin
    w_direct     = w_div0 | w_ovf | ~op[2];
    w_direct_res = '0;
    if (!op[2])
      w_direct_res = (op == 3'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    else if (w_div0)
      w_direct_res = op[1] ? src1 : '1;
    else
      w_direct_res = op[1] ? '0 : src1;
  end
`else
  always_comb begin
    w_direct     = w_div0 | w_ovf;
    w_direct_res = '0;
    if (w_div0)
      w_direct_res = op[1] ? src1 : '1;
    else
      w_direct_res = op[1] ? '0 : src1;
  end
`endif

  assign w_accept = start & ~flush & (r_state == S_IDLE);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = w_direct ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // One iteration step; r_hi is the upper accumulator / partial remainder,
  // r_lo the multiplier / dividend that shifts out as quotient bits shift in.
  logic [XLEN:0]     w_msum, w_dshift;
  logic [XLEN-1:0]   w_ddiff, w_hi_nx, w_lo_nx;
  logic              w_dge;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_iter_res, w_result;

  always_comb begin
    w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_dshift = {r_hi, r_lo[XLEN-1]};
    w_dge    = (w_dshift >= {1'b0, r_b});
    w_ddiff  = w_dshift[XLEN-1:0] - r_b;
    if (r_div) begin
      w_hi_nx = w_dge ? w_ddiff : w_dshift[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_dge};
    end else begin
      w_hi_nx = w_msum[XLEN:1];
      w_lo_nx = {w_msum[0], r_lo[XLEN-1:1]};
    end
    w_prod   = {w_hi_nx, w_lo_nx};
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo    = r_neg_q ? (~w_lo_nx + 1'b1) : w_lo_nx;
    w_rem    = r_neg_r ? (~w_hi_nx + 1'b1) : w_hi_nx;
    case (r_op)
      3'd0:          w_iter_res = w_prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_iter_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_iter_res = w_quo;
      default:       w_iter_res = w_rem;
    endcase
    w_result = (r_state == S_IDLE) ? w_direct_res : w_iter_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_rd    <= REG_X0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_rd    <= gprs_waddr_i;
      r_hi    <= '0;
      r_lo    <= w_abs1;
      r_b     <= w_abs2;
      r_cnt   <= CNT_INIT;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      r_div   <= op[2];
    end else if (r_state == S_BUSY) begin
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_waddr <= REG_X0;
      r_wdata <= '0;
    end else begin
      r_busy  <= (w_state_nx == S_BUSY);
      r_done  <= (w_state_nx == S_DONE);
      r_waddr <= REG_X0;
      r_wdata <= '0;
      if (w_state_nx == S_DONE) begin
        r_waddr <= w_accept ? gprs_waddr_i : r_rd;
        r_wdata <= w_result;
      end
    end
  end

  assign stall        = w_accept | (r_state == S_BUSY);
  assign busy         = r_busy;
  assign done         = r_done;
  assign gprs_waddr_o = r_waddr;
  assign gprs_wdata_o = r_wdata;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected writes, checked when done pulses.
module tb_ex_muldiv;
  localparam int XLEN = 32;
`ifdef EX_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [2:0] RST_OP = 3'd5;
`else
  localparam int MUL_LAT = XLEN + 1;
  localparam logic [2:0] RST_OP = 3'd0;
`endif

  logic clk = 1'b0;
  logic rst, start, flush;
  logic [2:0] op;
  logic [31:0] src1, src2;
  logic [4:0] waddr_i;
  logic stall, busy, done;
  logic [4:0] waddr_o;
  logic [31:0] wdata_o;

  ex_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .gprs_waddr_i(waddr_i), .flush(flush), .stall(stall), .busy(busy), .done(done),
    .gprs_waddr_o(waddr_o), .gprs_wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    int          issue;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (sbq.size() == 0) chk("spurious_done", {63'd0, done}, 64'd0);
        else begin
          mon_e = sbq.pop_front();
          chk("waddr", {59'd0, waddr_o}, {59'd0, mon_e.rd});
          chk("wdata", {32'd0, wdata_o}, {32'd0, mon_e.data});
          chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
        end
      end else begin
        chk("idle_waddr", {59'd0, waddr_o}, 64'd0);
        chk("idle_wdata", {32'd0, wdata_o}, 64'd0);
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    case (f_op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
    if (!f_op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f_op == 3'd4 || f_op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_data);
    exp_t e;
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    e.rd = rd; e.data = exp_data; e.lat = exp_lat(t_op, a, b); e.issue = cyc;
    sbq.push_back(e);
    start = 1'b1; op = t_op; src1 = a; src2 = b; waddr_i = rd;
    @(negedge clk);
    chk("stall_issue", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("stall_done", {63'd0, stall}, 64'd0);
        break;
      end
      chk("stall_busy", {63'd0, stall}, 64'd1);
      chk("busy_busy", {63'd0, busy}, 64'd1);
    end
    if (!got) chk("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int t0;
    logic [2:0] r_op;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0; waddr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_waddr", {59'd0, waddr_o}, 64'd0);
    chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
    run_op(3'd5, 32'd12345, 32'd0, 5'd13, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd9, 32'd0, 5'd14, 32'd9);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd17, 32'h0000_0000);
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);

    // start held into the DONE cycle must be ignored
    @(posedge clk); #1;
    begin
      exp_t e;
      e.rd = 5'd3; e.data = 32'hFFFF_FFFF; e.lat = 1; e.issue = cyc;
      sbq.push_back(e);
    end
    start = 1'b1; op = 3'd5; src1 = 32'd123; src2 = 32'd0; waddr_i = 5'd3;
    @(posedge clk); #1;
    op = 3'd0; src1 = 32'd5; src2 = 32'd6; waddr_i = 5'd4;
    @(negedge clk);
    chk("b2b_done", {63'd0, done}, 64'd1);
    chk("b2b_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {63'd0, busy}, 64'd0);
    chk("b2b_no_done", {63'd0, done}, 64'd0);

    // flush at cycle 10 of a DIV
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; op = 3'd4; src1 = 32'd1000; src2 = 32'd3; waddr_i = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_pre", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_post", {63'd0, busy}, 64'd0);
    chk("flush_stall_post", {63'd0, stall}, 64'd0);
    run_op(3'd0, 32'd1234, 32'd5678, 5'd20, 32'd7006652);

    // async reset at cycle 5 of an op
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; op = RST_OP; src1 = 32'd77; src2 = 32'd11; waddr_i = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_waddr", {59'd0, waddr_o}, 64'd0);
    chk("arst_wdata", {32'd0, wdata_o}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'd0;
        3: rb = 32'hFFFF_FFFF;
        default: rb = ~32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(r_op, ra, rb, 5'($urandom_range(0, 31)), ref_res(r_op, ra, rb));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
